ctrl_decode_pipe: RTL
=====================

CTRL_DECODE_PIPE -- requirements
Module: ctrl_decode_pipe

Interface
REQ-001 SHALL have parameter DEPTH, default 2: output buffer entries; legal values are powers of two from 1 to 8.
REQ-002 SHALL have parameter EN_M, default 0: 1 = R-type funct7=0000001 (M-extension) is decoded as legal.
REQ-003 SHALL have parameter EN_LUI, default 1: 1 = opcode 0110111 (LUI) is decoded as legal.
REQ-004 SHALL have parameter CNT_W, default 16: width of the illegal-instruction counter.
REQ-005 Reset rst_n, asynchronous, active-low; clock clk.
REQ-006 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port in_valid, input, 1: inst is valid this cycle.
REQ-009 SHALL have port in_ready, output, 1: the block can accept inst.
REQ-010 SHALL have port inst, input, 32: full instruction word.
REQ-011 SHALL have port flush, input, 1: synchronous discard of all buffered entries.
REQ-012 SHALL have port out_valid, output, 1: the head entry is valid.
REQ-013 SHALL have port out_ready, input, 1: the consumer takes the head entry.
REQ-014 SHALL have ports auipc, lui, jalr, jal, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, muldiv, illegal: each output, 1 bit, head-entry control flags.
REQ-015 SHALL have port alu_op, output, 2: head-entry ALU class (00 add, 01 branch compare, 10 funct-decoded).
REQ-016 SHALL have port out_inst, output, 32: head-entry instruction, passed through unchanged.
REQ-017 SHALL have port illegal_cnt, output, CNT_W: count of accepted illegal instructions.

Function
REQ-018 SHALL decode on opcode inst[6:0]; every flag not listed below is 0 and alu_op is 00 unless stated.
REQ-019 0110011 SHALL set reg_write and alu_op=10; with funct7=0000001, SHALL also set muldiv when EN_M=1 and SHALL instead be illegal when EN_M=0.
REQ-020 0010011 SHALL set alu_src, reg_write and alu_op=10.
REQ-021 0000011 SHALL set alu_src, mem_to_reg, reg_write and mem_read.
REQ-022 0100011 SHALL set alu_src and mem_write.
REQ-023 1100011 SHALL set branch and alu_op=01.
REQ-024 1100111 SHALL set jalr, alu_src and reg_write.
REQ-025 1101111 SHALL set jal and reg_write.
REQ-026 0010111 SHALL set auipc, alu_src and reg_write.
REQ-027 0110111 SHALL set lui, alu_src and reg_write when EN_LUI=1, and SHALL be illegal otherwise.
REQ-028 Any other opcode, or inst[1:0]!=11, SHALL produce illegal=1 with all other flags 0; the entry is still buffered.
REQ-029 Decoded flags and inst SHALL be stored in a DEPTH-entry circular FIFO using a read pointer, a write pointer and a count of 0..DEPTH.
REQ-030 in_ready SHALL equal (count<DEPTH) && !flush and SHALL have no combinational path from out_ready.
REQ-031 A push SHALL occur on in_valid && in_ready; a pop SHALL occur on out_valid && out_ready && !flush.
REQ-032 Latency: an entry accepted at edge N SHALL be presented with out_valid=1 after edge N, with no bypass path.
REQ-033 out_valid SHALL equal (count!=0).
REQ-034 When count=0, all flag outputs, alu_op and out_inst SHALL be 0.
REQ-035 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-036 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-037 Output head data SHALL hold stable while out_valid && !out_ready.
REQ-038 flush SHALL zero count and both pointers at the next edge, takes priority over push and pop, and SHALL NOT change illegal_cnt.
REQ-039 illegal_cnt SHALL increment on each push with illegal=1 and SHALL saturate at all-ones.

Reset
REQ-040 While rst_n=0: count, pointers and illegal_cnt SHALL be 0; out_valid, all flags, alu_op and out_inst SHALL be 0; in_ready SHALL be 0.
REQ-041 On the first edge after rst_n deasserts, in_ready SHALL be 1 (flush=0).
REQ-042 Reset mid-stream SHALL discard all entries with no partial output.

Verification
REQ-043 Push 0x00A00093, out_ready=1 -> next cycle out_valid=1, alu_src=1, reg_write=1, alu_op=10, other flags 0.
REQ-044 DEPTH=2, out_ready=0; push 0x0000A103, 0x0020A023, then 0x00208463 -> in_ready=0 after the 2nd push, the 3rd is not accepted, and the head shows mem_read=1, mem_to_reg=1.
REQ-045 EN_M=0, push 0x023100B3 then 0x0000007F -> both illegal=1 and illegal_cnt=2; with EN_M=1, 0x023100B3 gives muldiv=1, reg_write=1, alu_op=10.
REQ-046 Full FIFO with out_ready=1 and in_valid=1 continuously -> one pop and one push per cycle after the first pop, pointers wrap, order preserved.
REQ-047 flush with 2 entries plus a concurrent in_valid -> next cycle out_valid=0, the input is not accepted and illegal_cnt is unchanged.
REQ-048 Assert rst_n=0 mid-stream with entries buffered -> outputs are 0 immediately, and after release in_ready=1 and out_valid=0.

Source files
------------

// File: rtl/ctrl_decode_pipe.sv
// Instruction control decoder feeding a DEPTH-entry circular output FIFO.
// The head entry drives the control flags; the illegal count saturates at all-ones.
module ctrl_decode_pipe #(
   parameter int DEPTH  = 2,
   parameter int EN_M   = 0,
   parameter int EN_LUI = 1,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      inst,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             auipc,
   output logic             lui,
   output logic             jalr,
   output logic             jal,
   output logic             branch,
   output logic             mem_read,
   output logic             mem_to_reg,
   output logic             mem_write,
   output logic             alu_src,
   output logic             reg_write,
   output logic             muldiv,
   output logic             illegal,
   output logic [1:0]       alu_op,
   output logic [31:0]      out_inst,
   output logic [CNT_W-1:0] illegal_cnt
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int EW = 46;
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic          d_auipc, d_lui, d_jalr, d_jal, d_branch, d_mem_read, d_mem_to_reg;
   logic          d_mem_write, d_alu_src, d_reg_write, d_muldiv, d_illegal;
   logic [1:0]    d_alu_op;
   logic [EW-1:0] entry;

   always_comb begin
      d_auipc      = 1'b0;
      d_lui        = 1'b0;
      d_jalr       = 1'b0;
      d_jal        = 1'b0;
      d_branch     = 1'b0;
      d_mem_read   = 1'b0;
      d_mem_to_reg = 1'b0;
      d_mem_write  = 1'b0;
      d_alu_src    = 1'b0;
      d_reg_write  = 1'b0;
      d_muldiv     = 1'b0;
      d_illegal    = 1'b0;
      d_alu_op     = 2'b00;
      // every legal opcode ends in 2'b11, so a bad inst[1:0] falls to default
      case (inst[6:0])
         7'b0110011: begin
            if (inst[31:25] == 7'b0000001) begin
               if (EN_M != 0) begin
                  d_muldiv    = 1'b1;
                  d_reg_write = 1'b1;
                  d_alu_op    = 2'b10;
               end else begin
                  d_illegal   = 1'b1;
               end
            end else begin
               d_reg_write = 1'b1;
               d_alu_op    = 2'b10;
            end
         end
         7'b0010011: begin
            d_alu_src   = 1'b1;
            d_reg_write = 1'b1;
            d_alu_op    = 2'b10;
         end
         7'b0000011: begin
            d_alu_src    = 1'b1;
            d_mem_to_reg = 1'b1;
            d_reg_write  = 1'b1;
            d_mem_read   = 1'b1;
         end
         7'b0100011: begin
            d_alu_src   = 1'b1;
            d_mem_write = 1'b1;
         end
         7'b1100011: begin
            d_branch = 1'b1;
            d_alu_op = 2'b01;
         end
         7'b1100111: begin
            d_jalr      = 1'b1;
            d_alu_src   = 1'b1;
            d_reg_write = 1'b1;
         end
         7'b1101111: begin
            d_jal       = 1'b1;
            d_reg_write = 1'b1;
         end
         7'b0010111: begin
            d_auipc     = 1'b1;
            d_alu_src   = 1'b1;
            d_reg_write = 1'b1;
         end
         7'b0110111: begin
            if (EN_LUI != 0) begin
               d_lui       = 1'b1;
               d_alu_src   = 1'b1;
               d_reg_write = 1'b1;
            end else begin
               d_illegal   = 1'b1;
            end
         end
         default: d_illegal = 1'b1;
      endcase
   end

   assign entry = {d_auipc, d_lui, d_jalr, d_jal, d_branch, d_mem_read, d_mem_to_reg,
                   d_mem_write, d_alu_src, d_reg_write, d_muldiv, d_illegal, d_alu_op, inst};

   logic [EW-1:0]    mem_q [DEPTH];
   logic [EW-1:0]    mem_d [DEPTH];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;
   logic             rdy_q, rdy_d;
   logic             push, pop;
   logic [EW-1:0]    head;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + PW'(1);
   endfunction

   // rdy_q keeps in_ready low until the first edge out of reset
   assign in_ready  = rdy_q && (count_q < FULL) && !flush;
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready && !flush;

   always_comb begin
      mem_d     = mem_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      ill_cnt_d = ill_cnt_q;
      rdy_d     = 1'b1;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = entry;
            wr_ptr_d        = ptr_next(wr_ptr_q);
            if (d_illegal && (ill_cnt_q != '1))
               ill_cnt_d = ill_cnt_q + CNT_W'(1);
         end
         if (pop)
            rd_ptr_d = ptr_next(rd_ptr_q);
         if (push && !pop)
            count_d = count_q + CW'(1);
         else if (pop && !push)
            count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         ill_cnt_q <= '0;
         rdy_q     <= 1'b0;
      end else begin
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         ill_cnt_q <= ill_cnt_d;
         rdy_q     <= rdy_d;
      end
   end

   // payload storage needs no reset: it is masked whenever the FIFO is empty
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head = out_valid ? mem_q[rd_ptr_q] : '0;
   assign {auipc, lui, jalr, jal, branch, mem_read, mem_to_reg, mem_write,
           alu_src, reg_write, muldiv, illegal, alu_op, out_inst} = head;
   assign illegal_cnt = ill_cnt_q;

endmodule
